// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding,
// default operand width and a magnitude helper for signed operands.
package seq_mult_pkg;

    localparam int unsigned DefaultWidth = 4;
    localparam int unsigned MaxWidth     = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } multState_e;

    // Operand arrives sign- or zero-extended to MaxWidth+1 bits, so the most
    // negative WIDTH-bit value still has a representable magnitude.
    function automatic logic [MaxWidth:0] absVal(input logic [MaxWidth:0] val);
        return val[MaxWidth] ? (~val + 1'b1) : val;
    endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-add core: holds the multiplicand, the accumulator and the multiplier
// shift register, performing one add-and-shift per step.
module shift_add_datapath
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] productNext
);

    logic [WIDTH-1:0] accQ;
    logic [WIDTH-1:0] mplierQ;
    logic [WIDTH-1:0] mcandQ;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;

    // productNext is {carry, acc, mplier} after this step's add and right shift.
    always_comb begin
        addend      = mplierQ[0] ? {1'b0, mcandQ} : '0;
        sum         = {1'b0, accQ} + addend;
        productNext = {sum, mplierQ[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accQ    <= '0;
            mplierQ <= '0;
            mcandQ  <= '0;
        end else if (load) begin
            accQ    <= '0;
            mplierQ <= mplier;
            mcandQ  <= mcand;
        end else if (step) begin
            {accQ, mplierQ} <= productNext;
        end
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, one shift-add iteration per clock,
// with start/busy/done handshake and optional two's-complement operation.
module seq_shift_add_multiplier
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    multState_e         stateQ, stateD;
    logic [CNT_W-1:0]   cntQ;
    logic               negQ;
    logic [2*WIDTH-1:0] pQ;
    logic               load;
    logic               step;
    logic               lastStep;
    logic [MaxWidth:0]  extA;
    logic [MaxWidth:0]  extB;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [2*WIDTH-1:0] productNext;

    // Sign-extend only in signed mode; unsigned operands pass through absVal unchanged.
    always_comb begin
        extA = {{(MaxWidth + 1 - WIDTH){signed_mode & A[WIDTH-1]}}, A};
        extB = {{(MaxWidth + 1 - WIDTH){signed_mode & B[WIDTH-1]}}, B};
        magA = WIDTH'(absVal(extA));
        magB = WIDTH'(absVal(extB));
    end

    always_comb begin
        load     = (stateQ == StIdle) && start;
        step     = (stateQ == StRun);
        lastStep = step && (cntQ == CNT_W'(1));
    end

    shift_add_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .mcand      (magA),
        .mplier     (magB),
        .productNext(productNext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:  if (start) stateD = StRun;
            StRun:   if (cntQ == CNT_W'(1)) stateD = StDone;
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (stateQ)
            StIdle:  ;
            StRun:   busy = 1'b1;
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cntQ <= '0;
            negQ <= 1'b0;
            pQ   <= '0;
        end else begin
            if (load) begin
                cntQ <= CNT_W'(WIDTH);
                negQ <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            end else if (step) begin
                cntQ <= cntQ - 1'b1;
            end
            if (lastStep) begin
                pQ <= negQ ? (~productNext + 1'b1) : productNext;
            end
        end
    end

    assign P = pQ;

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
Parametrised sequential multiplier replacing fixed-width combinational multipliers. It multiplies two WIDTH-bit operands using one shift-add iteration per clock. Operands are accepted through a start/busy/done handshake, and the block supports unsigned or two's-complement signed operation. It sits beside the datapath as a shared arithmetic resource. It trades latency for area.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..16; product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  request; sampled only in IDLE.
signed_mode  input  1  1 = operands are two's complement; 0 = unsigned; sampled with start.
A  input  WIDTH  multiplicand; sampled with start.
B  input  WIDTH  multiplier; sampled with start.
busy  output  1  high in RUN and DONE states.
done  output  1  one-cycle pulse; P is valid and new.
P  output  2*WIDTH  product; holds last result until next done.

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE, busy=0, done=0, P=0, counter=0, internal registers=0. Reset wins over all other inputs. Reset mid-operation aborts the operation: no done pulse, P=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge k, capture operands and go to RUN.
  - In signed mode, capture |A| and |B| as WIDTH-bit unsigned magnitudes. The most-negative value maps to 2^(WIDTH-1), which fits. Also capture neg = sign(A) XOR sign(B).
  - In unsigned mode, capture A and B as-is with neg=0.
  - Set counter=WIDTH and accumulator=0.
  - If start=0, remain in IDLE.
- RUN: each edge performs one iteration.
  - If multiplier LSB=1, add the multiplicand into the upper WIDTH+1 bits of the accumulator.
  - Right-shift {carry, accumulator, multiplier} by 1.
  - Decrement the counter.
  - On the edge where the counter goes 1→0 (edge k+WIDTH), go to DONE. On that same edge, load P with the final product, two's-complement negated if neg=1, and set done=1.
- DONE: lasts exactly one cycle. done=1 and busy=1. On the next edge, go to IDLE with done=0 and busy=0.
- Latency: start sampled at edge k, so done=1 and P valid after edge k+WIDTH. The next start is accepted at edge k+WIDTH+2 at the earliest.
- Latency is fixed: no early termination for zero operands.
- start, A, B and signed_mode are ignored while busy=1. They need not be held after the accepting edge.
- P changes only on the edge that raises done, or on reset.
- Product width rules:
  - Unsigned: P = A*B, max (2^WIDTH−1)^2, fits in 2*WIDTH bits.
  - Signed: P = A*B as 2*WIDTH-bit two's complement. (−2^(W−1))^2 = 2^(2W−2) fits.
- Zero result in signed mode with neg=1 yields P=0 (negating 0 gives 0).

Decomposition:
- Shared package/header seq_mult_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a helper function for absolute value;
  - the default WIDTH.
- One sub-module is natural: shift_add_datapath. It holds the accumulator, multiplier shift register and adder, with load/step controls.
- The top level holds the FSM, counter, sign handling and output register.

Test Plan:
- WIDTH=4, unsigned, A=10, B=12, start pulse at edge k → busy=1 from edge k; done=1 only after edge k+4; P=8'd120 (0x78).
- WIDTH=4, signed_mode=1, A=4'b1101 (−3), B=4'b0101 (5) → P=8'hF1 (−15). A=4'b1000 (−8), B=4'b1000 (−8) → P=8'h40 (64).
- WIDTH=4, unsigned, A=15, B=15 → P=8'hE1 (225). Then A=0, B=9 → P=0, with latency still 4 cycles.
- start held high continuously with A=3, B=2, while A/B change to 7/7 during RUN → first result P=6. The next operation is captured only in IDLE (edge k+6), giving P=49. done is never high for 2 consecutive cycles.
- Assert rst for one edge two cycles after start → busy=0, done=0, P=0 the next cycle, and no done pulse follows. A new start then completes normally: A=2, B=3 → P=6.
- WIDTH=8 build, signed: A=−128, B=127 → P=16'hC080 (−16256) after 8 cycles. Unsigned: A=255, B=255 → P=16'hFE01.
